bitstream_arbiter: RTL and testbench

- Shares the fabric configuration port between two bitstream sources: a byte-wide serial loader (SPI/UART front end) and a 32-bit word-wide host interface.
- Grants one source per configuration session and packs bytes into 32-bit words.
- Drives the 32-bit data/valid input of the fabric configuration controller and releases the grant when that controller reports session end.
- Sits between the loader and host front ends and the fabric configuration controller.

---
 rtl/bitstream_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_bitstream_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bitstream_arbiter.sv
// Bitstream source arbiter: shares the fabric configuration port between a
// byte-wide serial loader and a 32-bit host interface. One source is granted
// per configuration session; bytes are packed MSB-first into 32-bit words.
// The session ends when the configuration controller drops busy after having
// raised it, or when the granted source stalls for TIMEOUT_CYCLES cycles.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | no grant; readies low; arbitrate pending valids (round-robin)
// S_GRANT | one source granted; its handshakes feed the configuration port

module bitstream_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_gated,
  input  logic        rst_ni,
  input  logic [7:0]  byte_data_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  input  logic [31:0] word_data_i,
  input  logic        word_valid_i,
  output logic        word_ready_o,
  input  logic        cfg_busy_i,
  output logic [31:0] bitstream_data_o,
  output logic        bitstream_valid_o,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  // A disabled timeout still gets a 1-bit counter so the ports of the
  // counter logic stay legal; it is never compared against.
  localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam int unsigned     TCW     = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TCW-1:0]  TO_LAST = TO_EN ? TCW'(TIMEOUT_CYCLES - 1) : '0;

  localparam logic [1:0] G_NONE = 2'b00;
  localparam logic [1:0] G_BYTE = 2'b01;
  localparam logic [1:0] G_WORD = 2'b10;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic            last_word_q, last_word_d;   // 1: word source held the last grant
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [23:0]     pack_q, pack_d;             // first three bytes of the word in flight
  logic            seen_busy_q, seen_busy_d;
  logic [TCW-1:0]  to_cnt_q, to_cnt_d;
  logic [31:0]     data_q, data_d;
  logic            valid_q, valid_d;
  logic            timeout_q, timeout_d;

  logic            in_grant;
  logic            byte_granted;
  logic            word_granted;
  logic            granted_valid;
  logic            timeout_hit;
  logic            sess_release;
  logic            byte_hs;
  logic            word_hs;

  // Session control: release detection and ready gating.
  // The timeout condition looks at the granted source's valid rather than at
  // the handshake itself, because the handshake depends on ready, which in
  // turn depends on the release. While no busy-driven release is pending the
  // two are equivalent: a valid source at the last count would handshake.
  always_comb begin
    in_grant      = (state_q == S_GRANT);
    byte_granted  = in_grant && (grant_q == G_BYTE);
    word_granted  = in_grant && (grant_q == G_WORD);
    granted_valid = (byte_granted && byte_valid_i) || (word_granted && word_valid_i);
    timeout_hit   = TO_EN && in_grant && (to_cnt_q == TO_LAST) && !granted_valid;
    sess_release  = in_grant && ((seen_busy_q && !cfg_busy_i) || timeout_hit);
    byte_ready_o  = byte_granted && !sess_release;
    word_ready_o  = word_granted && !sess_release;
    byte_hs       = byte_valid_i && byte_ready_o;
    word_hs       = word_valid_i && word_ready_o;
  end

  // Next-state computation for the FSM, packer, timeout counter and outputs.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_word_d = last_word_q;
    byte_cnt_d  = byte_cnt_q;
    pack_d      = pack_q;
    seen_busy_d = seen_busy_q;
    to_cnt_d    = to_cnt_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    timeout_d   = timeout_q;

    case (state_q)
      S_IDLE: begin
        // Byte source wins when alone, or on a tie when the word source
        // held the previous grant.
        if (byte_valid_i && (!word_valid_i || last_word_q)) begin
          state_d     = S_GRANT;
          grant_d     = G_BYTE;
          last_word_d = 1'b0;
          timeout_d   = 1'b0;
          byte_cnt_d  = 2'd0;
          seen_busy_d = 1'b0;
          to_cnt_d    = '0;
        end else if (word_valid_i) begin
          state_d     = S_GRANT;
          grant_d     = G_WORD;
          last_word_d = 1'b1;
          timeout_d   = 1'b0;
          byte_cnt_d  = 2'd0;
          seen_busy_d = 1'b0;
          to_cnt_d    = '0;
        end
      end

      S_GRANT: begin
        if (cfg_busy_i) begin
          seen_busy_d = 1'b1;
        end

        if (word_hs) begin
          data_d  = word_data_i;
          valid_d = 1'b1;
        end

        if (byte_hs) begin
          pack_d     = {pack_q[15:0], byte_data_i};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            data_d  = {pack_q, byte_data_i};
            valid_d = 1'b1;
          end
        end

        // Idle counter saturates instead of wrapping.
        if (byte_hs || word_hs) begin
          to_cnt_d = '0;
        end else if (to_cnt_q != '1) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end

        // Releasing discards any partially packed word.
        if (sess_release) begin
          state_d    = S_IDLE;
          grant_d    = G_NONE;
          byte_cnt_d = 2'd0;
          timeout_d  = timeout_hit;
        end
      end

      default: begin
        state_d = S_IDLE;
        grant_d = G_NONE;
      end
    endcase
  end

  // State and registered-output flops; reset returns everything to idle.
  always_ff @(posedge clk_gated or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      grant_q     <= G_NONE;
      last_word_q <= 1'b1;
      byte_cnt_q  <= 2'd0;
      pack_q      <= 24'd0;
      seen_busy_q <= 1'b0;
      to_cnt_q    <= '0;
      data_q      <= 32'd0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_word_q <= last_word_d;
      byte_cnt_q  <= byte_cnt_d;
      pack_q      <= pack_d;
      seen_busy_q <= seen_busy_d;
      to_cnt_q    <= to_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bitstream_data_o  = data_q;
  assign bitstream_valid_o = valid_q;
  assign grant_o           = grant_q;
  assign timeout_o         = timeout_q;

endmodule

// File: tb/tb_bitstream_arbiter.sv
// Directed bench for bitstream_arbiter with an 8-cycle timeout.

module tb_bitstream_arbiter;

  logic        clk_gated = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  byte_data_i = 8'h00;
  logic        byte_valid_i = 1'b0;
  logic        byte_ready_o;
  logic [31:0] word_data_i = 32'h0;
  logic        word_valid_i = 1'b0;
  logic        word_ready_o;
  logic        cfg_busy_i = 1'b0;
  logic [31:0] bitstream_data_o;
  logic        bitstream_valid_o;
  logic [1:0]  grant_o;
  logic        timeout_o;

  int checks = 0;
  int failures = 0;
  int vcnt = 0;
  int v0 = 0;

  bitstream_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk_gated         (clk_gated),
    .rst_ni            (rst_ni),
    .byte_data_i       (byte_data_i),
    .byte_valid_i      (byte_valid_i),
    .byte_ready_o      (byte_ready_o),
    .word_data_i       (word_data_i),
    .word_valid_i      (word_valid_i),
    .word_ready_o      (word_ready_o),
    .cfg_busy_i        (cfg_busy_i),
    .bitstream_data_o  (bitstream_data_o),
    .bitstream_valid_o (bitstream_valid_o),
    .grant_o           (grant_o),
    .timeout_o         (timeout_o)
  );

  always #5 clk_gated = ~clk_gated;

  // Count valid pulses, sampled mid-cycle.
  always @(negedge clk_gated) begin
    if (rst_ni && bitstream_valid_o) vcnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_gated);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic hs;
    hs = 1'b0;
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    #1;
    for (int i = 0; i < 20 && !hs; i++) begin
      hs = byte_ready_o;
      step();
    end
    byte_valid_i = 1'b0;
    chk("byte_handshake", 32'(hs), 32'h1);
  endtask

  task automatic send_word(input logic [31:0] w);
    logic hs;
    hs = 1'b0;
    word_valid_i = 1'b1;
    word_data_i  = w;
    #1;
    for (int i = 0; i < 20 && !hs; i++) begin
      hs = word_ready_o;
      step();
    end
    word_valid_i = 1'b0;
    chk("word_handshake", 32'(hs), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_grant", 32'(grant_o), 0);
    chk("rst_valid", 32'(bitstream_valid_o), 0);
    chk("rst_data", bitstream_data_o, 0);
    chk("rst_timeout", 32'(timeout_o), 0);
    chk("rst_bready", 32'(byte_ready_o), 0);
    chk("rst_wready", 32'(word_ready_o), 0);
    rst_ni = 1'b1;
    step();

    // Tie from reset: byte, then word, then byte
    byte_valid_i = 1'b1; byte_data_i = 8'h11;
    word_valid_i = 1'b1; word_data_i = 32'hCAFE0001;
    step();
    chk("tie1_grant", 32'(grant_o), 32'h1);
    chk("tie1_bready", 32'(byte_ready_o), 1);
    chk("tie1_wready", 32'(word_ready_o), 0);
    cfg_busy_i = 1'b1;
    step();
    chk("tie1_wready_b", 32'(word_ready_o), 0);
    cfg_busy_i = 1'b0;
    #1;
    chk("tie1_rel_bready", 32'(byte_ready_o), 0);
    chk("tie1_rel_wready", 32'(word_ready_o), 0);
    step();
    chk("tie1_idle", 32'(grant_o), 0);
    step();
    chk("tie2_grant", 32'(grant_o), 32'h2);
    chk("tie2_bready", 32'(byte_ready_o), 0);
    cfg_busy_i = 1'b1;
    step();
    cfg_busy_i = 1'b0;
    step();
    chk("tie2_idle", 32'(grant_o), 0);
    step();
    chk("tie3_grant", 32'(grant_o), 32'h1);
    byte_valid_i = 1'b0;
    word_valid_i = 1'b0;
    cfg_busy_i = 1'b1;
    step();
    cfg_busy_i = 1'b0;
    step();
    chk("tie3_idle", 32'(grant_o), 0);

    // Word-only session
    v0 = vcnt;
    send_word(32'hFAB0FAB1);
    chk("word_grant", 32'(grant_o), 32'h2);
    chk("word1_valid", 32'(bitstream_valid_o), 1);
    chk("word1_data", bitstream_data_o, 32'hFAB0FAB1);
    cfg_busy_i = 1'b1;
    #1;
    chk("word_ready_held", 32'(word_ready_o), 1);
    send_word(32'h00100000);
    chk("word2_valid", 32'(bitstream_valid_o), 1);
    chk("word2_data", bitstream_data_o, 32'h00100000);
    cfg_busy_i = 1'b0;
    #1;
    chk("word_rel_ready", 32'(word_ready_o), 0);
    chk("word_rel_grant", 32'(grant_o), 32'h2);
    step();
    chk("word_end_grant", 32'(grant_o), 0);
    chk("word_end_valid", 32'(bitstream_valid_o), 0);
    chk("word_pulses", vcnt - v0, 2);

    // Byte packing with gaps
    v0 = vcnt;
    send_byte(8'hFA);
    chk("byte_grant", 32'(grant_o), 32'h1);
    cfg_busy_i = 1'b1;
    step();
    send_byte(8'hB0); step();
    send_byte(8'hFA); step();
    send_byte(8'hB1);
    chk("pack1_valid", 32'(bitstream_valid_o), 1);
    chk("pack1_data", bitstream_data_o, 32'hFAB0FAB1);
    step();
    chk("pack1_pulse_end", 32'(bitstream_valid_o), 0);
    chk("pack1_hold", bitstream_data_o, 32'hFAB0FAB1);
    send_byte(8'h12); step();
    send_byte(8'h34); step();
    send_byte(8'h56); step();
    send_byte(8'h78);
    chk("pack2_valid", 32'(bitstream_valid_o), 1);
    chk("pack2_data", bitstream_data_o, 32'h12345678);
    cfg_busy_i = 1'b0;
    #1;
    chk("pack_rel_bready", 32'(byte_ready_o), 0);
    step();
    chk("pack_end_grant", 32'(grant_o), 0);
    chk("pack_pulses", vcnt - v0, 2);

    // Timeout after two bytes
    v0 = vcnt;
    send_byte(8'hAA);
    send_byte(8'hBB);
    step(7);
    chk("to_before_grant", 32'(grant_o), 32'h1);
    chk("to_before_flag", 32'(timeout_o), 0);
    chk("to_hit_bready", 32'(byte_ready_o), 0);
    step();
    chk("to_grant", 32'(grant_o), 0);
    chk("to_flag", 32'(timeout_o), 1);
    chk("to_no_partial", vcnt - v0, 0);
    word_valid_i = 1'b1;
    word_data_i  = 32'h0BADF00D;
    step();
    chk("to_next_grant", 32'(grant_o), 32'h2);
    chk("to_flag_cleared", 32'(timeout_o), 0);
    word_valid_i = 1'b0;
    cfg_busy_i = 1'b1;
    step();
    cfg_busy_i = 1'b0;
    step();
    chk("to_next_end", 32'(grant_o), 0);
    chk("to_next_flag", 32'(timeout_o), 0);

    // Reset mid-session
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    rst_ni = 1'b0;
    #1;
    chk("mrst_grant", 32'(grant_o), 0);
    chk("mrst_valid", 32'(bitstream_valid_o), 0);
    chk("mrst_data", bitstream_data_o, 0);
    chk("mrst_timeout", 32'(timeout_o), 0);
    chk("mrst_bready", 32'(byte_ready_o), 0);
    #2;
    rst_ni = 1'b1;
    step();
    v0 = vcnt;
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    send_byte(8'hD4);
    chk("post_rst_valid", 32'(bitstream_valid_o), 1);
    chk("post_rst_data", bitstream_data_o, 32'hA1B2C3D4);
    step();
    chk("post_rst_pulses", vcnt - v0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
